// File: rtl/sqrt_seq.sv
// sqrt_seq: sequential radix-2 non-restoring integer square root.
// Produces one root bit per cycle. A single fix-up cycle then makes the
// remainder non-negative. Results stay on root/remainder until the next
// operand is accepted.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on state. The producer holds radicand
// stable while in_valid is high. The unit holds root/remainder stable while
// out_valid is high.
module sqrt_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     radicand,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH/2-1:0]   root,
  output logic [WIDTH/2:0]     remainder,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int N  = WIDTH / 2;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t                state_q, state_nx;
  logic [WIDTH-1:0]      d_q, d_nx;
  logic [N-1:0]          q_q, q_nx;
  logic signed [N+1:0]   r_q, r_nx;
  logic [CW-1:0]         i_q, i_nx;

  // Shared iteration datapath. The partial remainder is shifted by two and
  // takes the next radicand bit pair. The sign of the old remainder selects
  // between subtracting (4Q+1) and adding (4Q+3).
  logic [1:0]            pair;
  logic signed [N+1:0]   r_shift;
  logic signed [N+1:0]   r_iter;
  logic signed [N+1:0]   r_fix;

  // Next partial remainder for one ITER step and for the FIX step.
  always_comb begin
    pair    = d_q[WIDTH-1 -: 2];
    r_shift = {r_q[N-1:0], pair};
    if (r_q[N+1])
      r_iter = r_shift + $signed({q_q, 2'b11});
    else
      r_iter = r_shift - $signed({q_q, 2'b01});
    r_fix = r_q + $signed({1'b0, q_q, 1'b1});
  end

  // State and datapath registers. Reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      i_q     <= '0;
    end else begin
      state_q <= state_nx;
      d_q     <= d_nx;
      q_q     <= q_nx;
      r_q     <= r_nx;
      i_q     <= i_nx;
    end
  end

  // Next-state and register-update logic. abort overrides everything and
  // freezes Q/R, so the last result stays visible.
  always_comb begin
    state_nx = state_q;
    d_nx     = d_q;
    q_nx     = q_q;
    r_nx     = r_q;
    i_nx     = i_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          d_nx     = radicand;
          q_nx     = '0;
          r_nx     = '0;
          i_nx     = CW'(N - 1);
          state_nx = ITER;
        end
      end
      ITER: begin
        r_nx = r_iter;
        q_nx = {q_q[N-2:0], ~r_iter[N+1]};
        d_nx = {d_q[WIDTH-3:0], 2'b00};
        if (i_q == '0)
          state_nx = FIX;
        else
          i_nx = i_q - CW'(1);
      end
      FIX: begin
        if (r_q[N+1])
          r_nx = r_fix;
        state_nx = DONE;
      end
      DONE: begin
        if (out_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (abort) begin
      state_nx = IDLE;
      d_nx     = d_q;
      q_nx     = q_q;
      r_nx     = r_q;
      i_nx     = i_q;
    end
  end

  // Status and result outputs.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == ITER) || (state_q == FIX);
    root      = q_q;
    remainder = r_q[N:0];
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_sqrt_seq.sv
// tb_sqrt_seq: directed checks on a 32-bit instance and an exhaustive sweep
// of an 8-bit instance with random consumer backpressure.
module tb_sqrt_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        in_valid, in_ready, abort, out_valid, out_ready, busy;
  logic [31:0] radicand;
  logic [15:0] root;
  logic [16:0] remainder;
  logic [1:0]  dbg_state;

  // 8-bit instance
  logic        in_valid_b, in_ready_b, abort_b, out_valid_b, out_ready_b, busy_b;
  logic [7:0]  radicand_b;
  logic [3:0]  root_b;
  logic [4:0]  remainder_b;
  logic [1:0]  dbg_state_b;

  sqrt_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .radicand(radicand), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .root(root), .remainder(remainder), .busy(busy),
    .dbg_state(dbg_state)
  );

  sqrt_seq #(.WIDTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .radicand(radicand_b), .abort(abort_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .root(root_b), .remainder(remainder_b), .busy(busy_b),
    .dbg_state(dbg_state_b)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Wait (bounded) for out_valid. Returns the number of edges waited.
  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_valid"}, out_valid, 1);
  endtask

  task automatic accept(input logic [31:0] d);
    int g;
    g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    in_valid = 1'b1;
    radicand = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] d,
                        input logic [15:0] exp_r, input logic [16:0] exp_rem,
                        input bit chk_lat);
    int lat;
    accept(d);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_in_ready"}, in_ready, 0);
    wait_valid(tag, lat);
    if (chk_lat) check({tag, "_latency"}, lat, 17);
    check({tag, "_root"}, root, exp_r);
    check({tag, "_rem"}, remainder, exp_rem);
    handshake();
    check({tag, "_idle"}, in_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    rst_n = 1'b0;
    in_valid = 0; abort = 0; out_ready = 0; radicand = '0;
    in_valid_b = 0; abort_b = 0; out_ready_b = 0; radicand_b = '0;
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_root", root, 0);
    check("rst_rem", remainder, 0);
    check("rst_state", dbg_state, 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("zero", 32'd0, 16'd0, 17'd0, 1'b1);
    run_op("max", 32'hFFFF_FFFF, 16'd65535, 17'd131070, 1'b1);
    run_op("million", 32'd1000000, 16'd1000, 17'd0, 1'b0);
    run_op("n99", 32'd99, 16'd9, 17'd18, 1'b0);

    // Backpressure: result held, in_valid pulses ignored, accept one
    // cycle after the handshake edge.
    accept(32'd50);
    wait_valid("bp", lat);
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_root", root, 7);
      check("bp_rem", remainder, 1);
      check("bp_in_ready", in_ready, 0);
      in_valid = k[0];
      radicand = 32'd16;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_still_done", dbg_state, 3);
    check("bp_root_after", root, 7);
    in_valid = 1'b1;
    radicand = 32'd16;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_hs_in_ready", in_ready, 1);
    check("bp_hs_out_valid", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_busy", busy, 1);
    check("bp_next_in_ready", in_ready, 0);
    wait_valid("bp16", lat);
    check("bp16_root", root, 4);
    check("bp16_rem", remainder, 0);
    handshake();

    // Abort at the 7th ITER cycle.
    accept(32'd1000000);
    repeat (6) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    run_op("n144", 32'd144, 16'd12, 17'd0, 1'b0);

    // abort together with in_valid in IDLE: nothing accepted, result kept.
    abort = 1'b1; in_valid = 1'b1; radicand = 32'd9;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    check("idle_abort_in_ready", in_ready, 1);
    check("idle_abort_busy", busy, 0);
    check("idle_abort_root", root, 12);

    // Asynchronous reset mid-ITER.
    accept(32'd1000000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_root", root, 0);
    check("mid_rst_rem", remainder, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("two", 32'd2, 16'd1, 17'd1, 1'b0);

    // 8-bit exhaustive sweep with random out_ready.
    for (int d = 0; d < 256; d++) begin
      int e;
      int guard;
      bit done;
      int r;
      logic [8:0] got;
      logic [8:0] want;
      e = 0;
      while ((e + 1) * (e + 1) <= d) e++;
      in_valid_b = 1'b1;
      radicand_b = d[7:0];
      @(posedge clk); #1;
      in_valid_b = 1'b0;
      want = {e[3:0], 5'(d - e * e)};
      exp_q.push_back(want);
      guard = 0;
      done = 1'b0;
      while (!done && guard < 200) begin
        out_ready_b = 1'($urandom_range(0, 1));
        if (out_valid_b && out_ready_b) begin
          got  = {root_b, remainder_b};
          want = exp_q.pop_front();
          check("w8_result", got, want);
          r = int'(root_b);
          check("w8_bound", (r * r <= d) && (d < (r + 1) * (r + 1)), 1);
          done = 1'b1;
        end
        @(posedge clk); #1;
        guard++;
      end
      out_ready_b = 1'b0;
      if (!done) check("w8_timeout", done, 1);
    end

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
